branch_metric_pingpong: RTL and testbench

- Next-generation branch-metric store for the SISO decoder.
- Accepts systematic, parity and optional a-priori LLRs per trellis step, and computes the S+P and S−P metrics.
- Stores them in a two-bank ping-pong buffer, so frame N+1 can be written while the alpha/beta recursion reads frame N.
- Read side returns all four transition metrics (gamma_00, gamma_01, gamma_10, gamma_11) for one address per cycle.

---
 rtl/branch_metric_pingpong_pkg.sv | 21 ++
 rtl/branch_metric_pingpong_if.sv | 35 +++
 rtl/branch_metric_pingpong_ram.sv | 26 ++
 rtl/branch_metric_pingpong.sv | 167 ++++++++++++++++
 tb/tb_branch_metric_pingpong.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_metric_pingpong_pkg.sv
// Shared constants, slice indices and helpers for the branch-metric ping-pong store.
package bm_pkg;

    localparam int DWIDTH_DEF      = 16;
    localparam int BRANCH_SIZE_DEF = 6144;
    localparam int ADDR_W          = $clog2(BRANCH_SIZE_DEF);
    localparam int OWIDTH_DEF      = DWIDTH_DEF + 2;

    // Position of each transition metric inside the packed gamma word, g00 in the LSBs.
    localparam int G00 = 0;
    localparam int G01 = 1;
    localparam int G10 = 2;
    localparam int G11 = 3;

    typedef logic signed [OWIDTH_DEF-1:0] metric_t;

    function automatic metric_t sext_to_ow(input logic signed [DWIDTH_DEF-1:0] x);
        return metric_t'(x);
    endfunction

endpackage

// File: rtl/branch_metric_pingpong_if.sv
// Write-beat, read-port and status signals of the branch-metric store.
interface branch_metric_pingpong_if
    import bm_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int ADDR_W = bm_pkg::ADDR_W,
    parameter int OWIDTH = DWIDTH + 2
) ();

    logic signed [DWIDTH-1:0] i_sys_item;
    logic signed [DWIDTH-1:0] i_parity_item;
    logic signed [DWIDTH-1:0] i_apriori_item;
    logic [ADDR_W-1:0]        i_addr;
    logic                     i_valid;
    logic                     i_last;
    logic                     o_ready;
    logic [ADDR_W-1:0]        i_rd_addr;
    logic                     i_rd_done;
    logic                     o_rd_avail;
    logic [4*OWIDTH-1:0]      o_gamma;
    logic                     o_addr_err;

    modport master (
        output i_sys_item, i_parity_item, i_apriori_item, i_addr, i_valid, i_last,
        output i_rd_addr, i_rd_done,
        input  o_ready, o_rd_avail, o_gamma, o_addr_err
    );

    modport slave (
        input  i_sys_item, i_parity_item, i_apriori_item, i_addr, i_valid, i_last,
        input  i_rd_addr, i_rd_done,
        output o_ready, o_rd_avail, o_gamma, o_addr_err
    );

endinterface

// File: rtl/branch_metric_pingpong_ram.sv
// Simple dual-port RAM: one synchronous write port and one registered read port.
module custom_ram #(
    parameter  int DWIDTH = 36,
    parameter  int DEPTH  = 6144,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DWIDTH-1:0] rdata
);

    logic [DWIDTH-1:0] mem [DEPTH];

    // NOTE: the array and its read register carry no reset so they map onto block RAM;
    // NOTE: clocked state is always assigned with <= so every reader sees pre-edge values.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/branch_metric_pingpong.sv
// Branch-metric store: computes S+P / S-P per trellis step and keeps two frames in
// ping-pong banks so the next frame is written while the recursion reads the current one.
module branch_metric_pingpong
    import bm_pkg::*;
#(
    parameter int DWIDTH      = DWIDTH_DEF,
    parameter int BRANCH_SIZE = BRANCH_SIZE_DEF,
    parameter int USE_APRIORI = 1,
    parameter int OWIDTH      = DWIDTH + 2
) (
    input  logic                    aclk,
    input  logic                    areset,
    branch_metric_pingpong_if.slave bus
);

    localparam int AW = $clog2(BRANCH_SIZE);
    localparam int MW = 2 * OWIDTH;

    typedef logic signed [OWIDTH-1:0] sum_t;

    typedef struct packed {
        sum_t          a;
        sum_t          b;
        logic [AW-1:0] addr;
        logic          bank;
        logic          last;
        logic          addr_ok;
    } stage1_t;

    logic          wr_sel;
    logic          rd_sel;
    logic [1:0]    busy;
    logic [1:0]    bank_ready;
    logic          ready;
    logic          accept;
    logic          addr_ok;
    logic          rd_release;
    logic          addr_err;

    sum_t          s_sum;
    sum_t          p_ext;
    stage1_t       s1_d;
    stage1_t       s1_q;
    logic          s1_valid;

    logic [1:0]    ram_we;
    logic [MW-1:0] ram_q [2];
    logic          rd_bank_q;
    logic          gamma_live;
    logic [MW-1:0] word;
    sum_t          g_a;
    sum_t          g_b;
    logic [4*OWIDTH-1:0] gamma;

    assign ready      = ~busy[wr_sel];
    assign accept     = bus.i_valid & ready;
    assign addr_ok    = int'(bus.i_addr) < BRANCH_SIZE;
    assign rd_release = bus.i_rd_done & bank_ready[rd_sel];

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        s_sum = sum_t'(bus.i_sys_item);
        if (USE_APRIORI != 0) begin
            s_sum = s_sum + sum_t'(bus.i_apriori_item);
        end
        p_ext        = sum_t'(bus.i_parity_item);
        s1_d.a       = s_sum + p_ext;
        s1_d.b       = s_sum - p_ext;
        s1_d.addr    = bus.i_addr;
        s1_d.bank    = wr_sel;
        s1_d.last    = bus.i_last;
        s1_d.addr_ok = addr_ok;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
        end
    end

    // Payload is qualified by s1_valid, so it needs no reset.
    always_ff @(posedge aclk) begin
        if (accept) begin
            s1_q <= s1_d;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            addr_err <= 1'b0;
        end else if (accept && !addr_ok) begin
            addr_err <= 1'b1;
        end
    end

    // Closing, committing and releasing a frame always touch different banks, so the
    // per-bit updates below never collide on the same cycle.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_sel     <= 1'b0;
            rd_sel     <= 1'b0;
            busy       <= 2'b00;
            bank_ready <= 2'b00;
        end else begin
            if (accept && bus.i_last) begin
                busy[wr_sel] <= 1'b1;
                wr_sel       <= ~wr_sel;
            end
            if (s1_valid && s1_q.last) begin
                bank_ready[s1_q.bank] <= 1'b1;
            end
            if (rd_release) begin
                busy[rd_sel]       <= 1'b0;
                bank_ready[rd_sel] <= 1'b0;
                rd_sel             <= ~rd_sel;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign ram_we[b] = s1_valid & s1_q.addr_ok & (s1_q.bank == 1'(b));

        custom_ram #(
            .DWIDTH (MW),
            .DEPTH  (BRANCH_SIZE)
        ) u_ram (
            .clk   (aclk),
            .we    (ram_we[b]),
            .waddr (s1_q.addr),
            .wdata ({s1_q.a, s1_q.b}),
            .raddr (bus.i_rd_addr),
            .rdata (ram_q[b])
        );
    end

    // gamma_live keeps o_gamma at zero from reset until the RAM read register has been loaded.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rd_bank_q  <= 1'b0;
            gamma_live <= 1'b0;
        end else begin
            rd_bank_q  <= rd_sel;
            gamma_live <= 1'b1;
        end
    end

    always_comb begin
        word  = ram_q[rd_bank_q];
        g_a   = word[MW-1:OWIDTH];
        g_b   = word[OWIDTH-1:0];
        gamma = '0;
        if (gamma_live) begin
            gamma[G11*OWIDTH +: OWIDTH] = g_a;
            gamma[G10*OWIDTH +: OWIDTH] = g_b;
            gamma[G01*OWIDTH +: OWIDTH] = -g_b;
            gamma[G00*OWIDTH +: OWIDTH] = -g_a;
        end
    end

    assign bus.o_ready    = ready;
    assign bus.o_rd_avail = bank_ready[rd_sel];
    assign bus.o_gamma    = gamma;
    assign bus.o_addr_err = addr_err;

endmodule

// File: tb/tb_branch_metric_pingpong.sv
// Self-checking bench: frame-level reference model plus directed literal checks and random traffic.
module tb_branch_metric_pingpong;
    import bm_pkg::*;

    localparam int BS = 6144;
    localparam int AW = 13;
    localparam int OW = 18;

    logic clk    = 1'b0;
    logic areset = 1'b1;

    int n_pass  = 0;
    int n_total = 0;

    branch_metric_pingpong_if #(.DWIDTH(16), .ADDR_W(AW), .OWIDTH(OW)) bus1 ();
    branch_metric_pingpong_if #(.DWIDTH(16), .ADDR_W(AW), .OWIDTH(OW)) bus0 ();

    branch_metric_pingpong #(.DWIDTH(16), .BRANCH_SIZE(BS), .USE_APRIORI(1)) dut (
        .aclk   (clk),
        .areset (areset),
        .bus    (bus1)
    );

    branch_metric_pingpong #(.DWIDTH(16), .BRANCH_SIZE(BS), .USE_APRIORI(0)) dut_noapr (
        .aclk   (clk),
        .areset (areset),
        .bus    (bus0)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int gsl(input logic [4*OW-1:0] g, input int idx);
        logic signed [OW-1:0] v;
        v = g[idx*OW +: OW];
        return int'(v);
    endfunction

    // ---------------- reference model (frame level) ----------------
    int mem_a [2][BS];
    int mem_b [2][BS];
    bit known [2][BS];
    int commit_q[$];      // commit edge of each closed, unreleased frame, oldest first
    int edge_n = 0;
    int wr_ptr = 0;
    int rd_ptr = 0;
    bit m_ready = 1'b1;
    bit m_avail = 1'b0;
    bit m_err   = 1'b0;
    bit pend_v  = 1'b0;
    int pend_bank, pend_addr, pend_a, pend_b;
    bit exp_gv  = 1'b0;
    int exp_a, exp_b;

    initial begin : model
        bit acc;
        int s, p, ra;
        forever begin
            @(posedge clk or posedge areset);
            if (areset) begin
                commit_q.delete();
                wr_ptr  = 0;
                rd_ptr  = 0;
                m_ready = 1'b1;
                m_avail = 1'b0;
                m_err   = 1'b0;
                pend_v  = 1'b0;
                exp_gv  = 1'b0;
                foreach (known[b, a]) known[b][a] = 1'b0;
            end else begin
                edge_n++;
                // read sees memory as it was before this edge
                ra     = int'(bus1.i_rd_addr);
                exp_gv = 1'b0;
                if (m_avail && ra < BS && known[rd_ptr][ra]) begin
                    exp_gv = 1'b1;
                    exp_a  = mem_a[rd_ptr][ra];
                    exp_b  = mem_b[rd_ptr][ra];
                end
                if (pend_v && pend_addr < BS) begin
                    mem_a[pend_bank][pend_addr] = pend_a;
                    mem_b[pend_bank][pend_addr] = pend_b;
                    known[pend_bank][pend_addr] = 1'b1;
                end
                acc = bus1.i_valid && m_ready;
                if (bus1.i_rd_done && m_avail) begin
                    void'(commit_q.pop_front());
                    rd_ptr ^= 1;
                end
                pend_v = acc;
                if (acc) begin
                    s = int'(bus1.i_sys_item) + int'(bus1.i_apriori_item);
                    p = int'(bus1.i_parity_item);
                    pend_bank = wr_ptr;
                    pend_addr = int'(bus1.i_addr);
                    pend_a    = s + p;
                    pend_b    = s - p;
                    if (pend_addr >= BS) m_err = 1'b1;
                    if (bus1.i_last) begin
                        commit_q.push_back(edge_n + 1);
                        wr_ptr ^= 1;
                    end
                end
                m_ready = commit_q.size() < 2;
                m_avail = commit_q.size() > 0 && commit_q[0] <= edge_n;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            check("o_ready", int'(bus1.o_ready), int'(m_ready));
            check("o_rd_avail", int'(bus1.o_rd_avail), int'(m_avail));
            check("o_addr_err", int'(bus1.o_addr_err), int'(m_err));
            if (exp_gv && !areset) begin
                check("model.g11", gsl(bus1.o_gamma, G11), exp_a);
                check("model.g10", gsl(bus1.o_gamma, G10), exp_b);
                check("model.g01", gsl(bus1.o_gamma, G01), -exp_b);
                check("model.g00", gsl(bus1.o_gamma, G00), -exp_a);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic beat(input int addr, input int sys, input int par, input int apr,
                        input bit last, input bit dual = 1'b0);
        int n;
        n = 0;
        bus1.i_addr         = AW'(addr);
        bus1.i_sys_item     = 16'(sys);
        bus1.i_parity_item  = 16'(par);
        bus1.i_apriori_item = 16'(apr);
        bus1.i_last         = last;
        bus1.i_valid        = 1'b1;
        if (dual) begin
            bus0.i_addr         = AW'(addr);
            bus0.i_sys_item     = 16'(sys);
            bus0.i_parity_item  = 16'(par);
            bus0.i_apriori_item = 16'(apr);
            bus0.i_last         = last;
            bus0.i_valid        = 1'b1;
        end
        while (!bus1.o_ready && n < 50) begin
            tick();
            n++;
        end
        check("beat_accept", int'(bus1.o_ready), 1);
        tick();
        bus1.i_valid = 1'b0;
        bus1.i_last  = 1'b0;
        bus0.i_valid = 1'b0;
        bus0.i_last  = 1'b0;
    endtask

    task automatic pulse_done();
        bus1.i_rd_done = 1'b1;
        tick();
        bus1.i_rd_done = 1'b0;
    endtask

    task automatic read_check(input string tag, input int addr,
                              input int g11, input int g10, input int g01, input int g00);
        bus1.i_rd_addr = AW'(addr);
        tick();
        check({tag, ".g11"}, gsl(bus1.o_gamma, G11), g11);
        check({tag, ".g10"}, gsl(bus1.o_gamma, G10), g10);
        check({tag, ".g01"}, gsl(bus1.o_gamma, G01), g01);
        check({tag, ".g00"}, gsl(bus1.o_gamma, G00), g00);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".o_ready"}, int'(bus1.o_ready), 1);
        check({tag, ".o_rd_avail"}, int'(bus1.o_rd_avail), 0);
        check({tag, ".o_gamma_nonzero"}, int'(|bus1.o_gamma), 0);
        check({tag, ".o_addr_err"}, int'(bus1.o_addr_err), 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int sys1 [4] = '{100, -50, 7, 0};
        int par1 [4] = '{20, 30, -7, 0};
        int c_addr [6] = '{0, 1, 2, 3, 4, 2048};

        bus1.i_sys_item = '0; bus1.i_parity_item = '0; bus1.i_apriori_item = '0;
        bus1.i_addr = '0; bus1.i_valid = 1'b0; bus1.i_last = 1'b0;
        bus1.i_rd_addr = '0; bus1.i_rd_done = 1'b0;
        bus0.i_sys_item = '0; bus0.i_parity_item = '0; bus0.i_apriori_item = '0;
        bus0.i_addr = '0; bus0.i_valid = 1'b0; bus0.i_last = 1'b0;
        bus0.i_rd_addr = '0; bus0.i_rd_done = 1'b0;

        tick();
        check_reset_values("reset");
        tick();
        areset = 1'b0;
        tick();

        // Single frame into bank 0
        for (int i = 0; i < 4; i++) beat(i, sys1[i], par1[i], 0, i == 3);
        check("single.avail_at_1", int'(bus1.o_rd_avail), 0);
        tick();
        check("single.avail_at_2", int'(bus1.o_rd_avail), 1);
        read_check("single.a0", 0, 120, 80, -80, -120);
        read_check("single.a1", 1, -20, -80, 80, 20);
        pulse_done();
        check("single.released", int'(bus1.o_rd_avail), 0);

        // Ping-pong: frame A (bank 1) then frame B (bank 0), no release in between
        for (int i = 0; i < 4; i++) beat(i, 10 * i, 1, 0, i == 3);
        for (int i = 0; i < 4; i++) beat(i, -(i + 1) * 100, 3, 0, i == 3);
        check("pp.ready_full", int'(bus1.o_ready), 0);
        check("pp.avail_a", int'(bus1.o_rd_avail), 1);
        pulse_done();
        check("pp.ready_freed", int'(bus1.o_ready), 1);
        check("pp.avail_b", int'(bus1.o_rd_avail), 1);
        read_check("pp.b0", 0, -97, -103, 103, 97);
        read_check("pp.b3", 3, -397, -403, 403, 397);

        // Concurrent: frame C into bank 1 while frame B is read
        for (int i = 0; i < 6; i++) begin
            bus1.i_rd_addr = AW'(i % 4);
            beat(c_addr[i], 1000 + i, -5 * i, i, i == 5);
        end
        read_check("conc.still_b", 0, -97, -103, 103, 97);
        pulse_done();
        read_check("conc.c0", 0, 1000, 1000, -1000, -1000);
        read_check("conc.c2048", 2048, 985, 1035, -1035, -985);

        // A-priori on/off: same beat into both instances
        bus0.i_rd_addr = AW'(5);
        beat(5, 32767, 32767, 32767, 1'b1, 1'b1);
        pulse_done();
        read_check("apr.on", 5, 98301, 32767, -32767, -98301);
        check("apr.off.avail", int'(bus0.o_rd_avail), 1);
        check("apr.off.g11", gsl(bus0.o_gamma, G11), 65534);
        check("apr.off.g10", gsl(bus0.o_gamma, G10), 0);
        check("apr.off.g00", gsl(bus0.o_gamma, G00), -65534);

        // Out-of-range address: closes the frame, writes nothing, flag is sticky
        beat(BS, 11, 22, 33, 1'b1);
        check("aerr.set", int'(bus1.o_addr_err), 1);
        tick();
        tick();
        check("aerr.sticky", int'(bus1.o_addr_err), 1);
        pulse_done();
        check("aerr.avail", int'(bus1.o_rd_avail), 1);
        read_check("aerr.c0_kept", 0, 1000, 1000, -1000, -1000);
        read_check("aerr.c2048_kept", 2048, 985, 1035, -1035, -985);

        // Reset mid-frame, then a fresh frame into bank 0
        beat(0, 5, 5, 5, 1'b0);
        beat(1, 6, 6, 6, 1'b0);
        areset = 1'b1;
        #1;
        check_reset_values("midrst");
        tick();
        tick();
        areset = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) beat(i, 3 * i, -i, 1, i == 2);
        check("fresh.avail_at_1", int'(bus1.o_rd_avail), 0);
        tick();
        check("fresh.avail_at_2", int'(bus1.o_rd_avail), 1);
        read_check("fresh.a2", 2, 5, 9, -9, -5);
        read_check("fresh.a0", 0, 1, 1, -1, -1);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            bus1.i_valid        = ($urandom_range(0, 1) == 1);
            bus1.i_last         = ($urandom_range(0, 3) == 0);
            bus1.i_addr         = ($urandom_range(0, 31) == 0) ? AW'(BS + $urandom_range(0, 2000))
                                                               : AW'($urandom_range(0, 15));
            bus1.i_sys_item     = 16'($urandom);
            bus1.i_parity_item  = 16'($urandom);
            bus1.i_apriori_item = 16'($urandom);
            bus1.i_rd_addr      = AW'($urandom_range(0, 15));
            bus1.i_rd_done      = ($urandom_range(0, 5) == 0);
            tick();
        end
        bus1.i_valid   = 1'b0;
        bus1.i_last    = 1'b0;
        bus1.i_rd_done = 1'b0;
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
